adler32_verify: RTL and testbench

- Downstream consumer of the Adler-32 checksum generator.
- Captures the generator's 32-bit checksum when its `valid` pulse arrives.
- Assembles the 4-byte checksum trailer sent with the frame, compares the two, and reports one pass/fail/timeout result per frame.
- Keeps pass/fail statistics for the link-integrity monitor.

---
 rtl/adler32_verify.sv | 197 +++++++++++++++++++
 tb/tb_adler32_verify.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/adler32_verify.sv
// adler32_verify: checks the checksum computed by the Adler-32 generator
// against the 4-byte big-endian trailer that arrives with the frame. Each
// frame gets exactly one verdict: match, mismatch, timeout or overrun.
// The operands can arrive in either order, or in the same cycle.
//
// Optional build macro ADLER_STATS_EN enables the saturating pass/fail
// statistic counters. When it is not defined, both counters are tied to
// zero and stat_clr is ignored.

module adler32_verify #(
    parameter int TIMEOUT = 64,  // cycles allowed between the two operand captures (>= 4)
    parameter int CNT_W   = 16   // width of the statistic counters
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      calc_checksum,
    input  logic             calc_valid,
    input  logic [7:0]       trl_data,
    input  logic             trl_valid,
    input  logic             stat_clr,
    output logic             result_valid,
    output logic             match,
    output logic             timeout,
    output logic             overrun,
    output logic [31:0]      rx_checksum,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count
);

    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GATHER  = 2'd1,
        COMPARE = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [2:0]    idx, idx_n;            // next trailer byte position, 4 = trailer complete
    logic          calc_held, calc_held_n;
    logic [31:0]   calc_q, calc_n;
    logic [31:0]   rx_q, rx_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          to_q, to_n;
    logic          ovr_q, ovr_n;
    logic          ovr_evt;
    logic          verdict_ok;

    // A frame passes only when it completed normally and both values agree
    assign verdict_ok  = (rx_q == calc_q) & ~to_q & ~ovr_q;
    assign rx_checksum = rx_q;

    // State and operand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 3'd0;
            calc_held <= 1'b0;
            calc_q    <= 32'd0;
            rx_q      <= 32'd0;
            tcnt      <= '0;
            to_q      <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            calc_held <= calc_held_n;
            calc_q    <= calc_n;
            rx_q      <= rx_n;
            tcnt      <= tcnt_n;
            to_q      <= to_n;
            ovr_q     <= ovr_n;
        end
    end

    // Next-state logic: operand capture, completion, overrun and timeout
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        calc_held_n = calc_held;
        calc_n      = calc_q;
        rx_n        = rx_q;
        tcnt_n      = tcnt;
        to_n        = to_q;
        ovr_n       = ovr_q;
        ovr_evt     = 1'b0;

        case (state)
            IDLE, COMPARE: begin
                // COMPARE lasts one cycle. It clears the frame state, but it
                // still accepts the first operand of the next frame, so a
                // back-to-back frame loses nothing.
                if (state == COMPARE) begin
                    state_n     = IDLE;
                    idx_n       = 3'd0;
                    calc_held_n = 1'b0;
                    to_n        = 1'b0;
                    ovr_n       = 1'b0;
                end
                if (calc_valid) begin
                    calc_n      = calc_checksum;
                    calc_held_n = 1'b1;
                end
                if (trl_valid) begin
                    rx_n[31:24] = trl_data;
                    idx_n       = 3'd1;
                end
                if (calc_valid || trl_valid) begin
                    state_n = GATHER;
                    tcnt_n  = '0;
                end
            end

            GATHER: begin
                tcnt_n  = tcnt + TW'(1);
                ovr_evt = (trl_valid && idx[2]) || (calc_valid && calc_held);

                // A 5th trailer byte is dropped, so rx keeps the 4 real bytes
                if (trl_valid && !idx[2]) begin
                    case (idx[1:0])
                        2'd0:    rx_n[31:24] = trl_data;
                        2'd1:    rx_n[23:16] = trl_data;
                        2'd2:    rx_n[15:8]  = trl_data;
                        default: rx_n[7:0]   = trl_data;
                    endcase
                    idx_n = idx + 3'd1;
                end
                if (calc_valid && !calc_held) begin
                    calc_n      = calc_checksum;
                    calc_held_n = 1'b1;
                end

                // A protocol violation outranks everything else. An operand
                // set that becomes complete on the same edge as the timeout
                // still counts as complete.
                if (ovr_evt) begin
                    ovr_n   = 1'b1;
                    state_n = COMPARE;
                end else if (idx_n[2] && calc_held_n) begin
                    state_n = COMPARE;
                end else if (tcnt == TW'(TIMEOUT - 2)) begin
                    to_n    = 1'b1;
                    state_n = COMPARE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Verdict outputs: registered out of COMPARE and high for exactly one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_valid <= 1'b0;
            match        <= 1'b0;
            timeout      <= 1'b0;
            overrun      <= 1'b0;
        end else if (state == COMPARE) begin
            result_valid <= 1'b1;
            match        <= verdict_ok;
            timeout      <= to_q;
            overrun      <= ovr_q;
        end else begin
            result_valid <= 1'b0;
            match        <= 1'b0;
            timeout      <= 1'b0;
            overrun      <= 1'b0;
        end
    end

`ifdef ADLER_STATS_EN
    // Saturating pass/fail counters; a clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_count <= '0;
            fail_count <= '0;
        end else if (stat_clr) begin
            pass_count <= '0;
            fail_count <= '0;
        end else if (state == COMPARE) begin
            if (verdict_ok) begin
                if (pass_count != {CNT_W{1'b1}}) pass_count <= pass_count + 1'b1;
            end else begin
                if (fail_count != {CNT_W{1'b1}}) fail_count <= fail_count + 1'b1;
            end
        end
    end
`else
    logic stat_clr_unused;
    assign stat_clr_unused = stat_clr;
    assign pass_count      = '0;
    assign fail_count      = '0;
`endif

endmodule

// File: tb/tb_adler32_verify.sv
// Bench for adler32_verify. Stimulus and expected verdicts are pushed into
// a scoreboard queue. A separate negedge monitor pops one entry each time
// result_valid is seen and compares it against the DUT outputs.
module tb_adler32_verify;

    localparam int  TIMEOUT = 64;
    localparam int  CNT_W   = 16;
    localparam time PER     = 10;
    localparam time HALF    = 5;
`ifdef ADLER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [31:0]      calc_checksum = '0;
    logic             calc_valid = 1'b0;
    logic [7:0]       trl_data = '0;
    logic             trl_valid = 1'b0;
    logic             stat_clr = 1'b0;
    logic             result_valid, match, timeout, overrun;
    logic [31:0]      rx_checksum;
    logic [CNT_W-1:0] pass_count, fail_count;

    always #(HALF) clk = ~clk;

    adler32_verify #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .calc_checksum(calc_checksum), .calc_valid(calc_valid),
        .trl_data(trl_data), .trl_valid(trl_valid), .stat_clr(stat_clr),
        .result_valid(result_valid), .match(match), .timeout(timeout),
        .overrun(overrun), .rx_checksum(rx_checksum),
        .pass_count(pass_count), .fail_count(fail_count)
    );

    typedef struct {
        logic        m;
        logic        t;
        logic        o;
        logic [31:0] rx;
        int          pc;
        int          fc;
        time         te;   // edge at which result_valid is expected to rise
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_pass = 0;
    int   exp_fail = 0;
    time  t_cap;
    time  t0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // One clock of stimulus; t_cap records the edge that samples it
    task automatic cyc(input logic tv, input logic [7:0] td, input logic cv,
                       input logic [31:0] cd, input logic clr);
        trl_valid = tv; trl_data = td; calc_valid = cv; calc_checksum = cd; stat_clr = clr;
        @(posedge clk);
        t_cap = $time;
        #1;
        trl_valid = 1'b0; calc_valid = 1'b0; stat_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic expect_res(input logic m, input logic t, input logic o,
                              input logic [31:0] rx, input time te, input logic clr);
        exp_t e;
        if (clr) begin
            exp_pass = 0; exp_fail = 0;
        end else if (m) begin
            exp_pass++;
        end else begin
            exp_fail++;
        end
        e.m = m; e.t = t; e.o = o; e.rx = rx; e.te = te;
        e.pc = STATS ? exp_pass : 0;
        e.fc = STATS ? exp_fail : 0;
        q.push_back(e);
    endtask

    // Monitor: pops one expected verdict per result_valid pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            if (result_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: result_valid=1 with no verdict pending at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("match",      64'(match),       64'(e.m));
                    chk("timeout",    64'(timeout),     64'(e.t));
                    chk("overrun",    64'(overrun),     64'(e.o));
                    chk("rx",         64'(rx_checksum), 64'(e.rx));
                    chk("pass_count", 64'(pass_count),  64'(e.pc));
                    chk("fail_count", 64'(fail_count),  64'(e.fc));
                    chk("latency",    64'($time - HALF), 64'(e.te));
                end
            end else begin
                chk("flags_idle", 64'({match, timeout, overrun}), 64'(0));
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result_valid", 64'(result_valid), 0);
        chk("rst_match",        64'(match), 0);
        chk("rst_timeout",      64'(timeout), 0);
        chk("rst_overrun",      64'(overrun), 0);
        chk("rst_rx",           64'(rx_checksum), 0);
        chk("rst_pass",         64'(pass_count), 0);
        chk("rst_fail",         64'(fail_count), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Matching frame: checksum first, trailer 4 cycles later
        cyc(0, 8'h00, 1, 32'h11E60398, 0);
        idle(3);
        cyc(1, 8'h11, 0, 0, 0); cyc(1, 8'hE6, 0, 0, 0); cyc(1, 8'h03, 0, 0, 0);
        cyc(1, 8'h98, 0, 0, 0);
        expect_res(1, 0, 0, 32'h11E60398, t_cap + PER, 0);
        idle(3);

        // Trailer first, with a corrupted last byte
        cyc(1, 8'h11, 0, 0, 0); cyc(1, 8'hE6, 0, 0, 0); cyc(1, 8'h03, 0, 0, 0);
        cyc(1, 8'h99, 0, 0, 0);
        cyc(0, 8'h00, 1, 32'h11E60398, 0);
        expect_res(0, 0, 0, 32'h11E60399, t_cap + PER, 0);
        idle(3);

        // 4th byte and checksum on the same edge
        cyc(1, 8'h11, 0, 0, 0); cyc(1, 8'hE6, 0, 0, 0); cyc(1, 8'h03, 0, 0, 0);
        cyc(1, 8'h98, 1, 32'h11E60398, 0);
        expect_res(1, 0, 0, 32'h11E60398, t_cap + PER, 0);
        idle(3);

        // Timeout: checksum only; rx keeps the previous trailer
        cyc(0, 8'h00, 1, 32'hDEADBEEF, 0);
        t0 = t_cap;
        expect_res(0, 1, 0, 32'h11E60398, t0 + TIMEOUT * PER, 0);
        idle(TIMEOUT + 6);

        // Overrun: second checksum 3 cycles after the first
        cyc(0, 8'h00, 1, 32'h00000001, 0);
        idle(2);
        cyc(0, 8'h00, 1, 32'h00000002, 0);
        expect_res(0, 0, 1, 32'h11E60398, t_cap + PER, 0);
        idle(3);
        // The next good frame still matches
        cyc(0, 8'h00, 1, 32'h00010001, 0);
        cyc(1, 8'h00, 0, 0, 0); cyc(1, 8'h01, 0, 0, 0); cyc(1, 8'h00, 0, 0, 0);
        cyc(1, 8'h01, 0, 0, 0);
        expect_res(1, 0, 0, 32'h00010001, t_cap + PER, 0);
        idle(3);

        // Overrun: a 5th trailer byte is not written into rx
        cyc(1, 8'hAA, 0, 0, 0); cyc(1, 8'hBB, 0, 0, 0); cyc(1, 8'hCC, 0, 0, 0);
        cyc(1, 8'hDD, 0, 0, 0); cyc(1, 8'hEE, 0, 0, 0);
        expect_res(0, 0, 1, 32'hAABBCCDD, t_cap + PER, 0);
        idle(3);

        // Back-to-back: the next frame's checksum arrives in the COMPARE cycle
        cyc(1, 8'h12, 0, 0, 0); cyc(1, 8'h34, 0, 0, 0); cyc(1, 8'h56, 0, 0, 0);
        cyc(1, 8'h78, 1, 32'h12345678, 0);
        expect_res(1, 0, 0, 32'h12345678, t_cap + PER, 0);
        cyc(0, 8'h00, 1, 32'hCAFEBABE, 0);
        cyc(1, 8'hCA, 0, 0, 0); cyc(1, 8'hFE, 0, 0, 0); cyc(1, 8'hBA, 0, 0, 0);
        cyc(1, 8'hBE, 0, 0, 0);
        expect_res(1, 0, 0, 32'hCAFEBABE, t_cap + PER, 0);
        idle(3);

        // Reset mid-frame: no verdict, and everything goes back to zero
        cyc(1, 8'h01, 0, 0, 0); cyc(1, 8'h02, 0, 0, 0);
        rst_n = 1'b0;
        exp_pass = 0; exp_fail = 0;
        #2;
        chk("midrst_result_valid", 64'(result_valid), 0);
        chk("midrst_rx",           64'(rx_checksum), 0);
        chk("midrst_pass",         64'(pass_count), 0);
        chk("midrst_fail",         64'(fail_count), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        cyc(0, 8'h00, 1, 32'h0A0B0C0D, 0);
        cyc(1, 8'h0A, 0, 0, 0); cyc(1, 8'h0B, 0, 0, 0); cyc(1, 8'h0C, 0, 0, 0);
        cyc(1, 8'h0D, 0, 0, 0);
        expect_res(1, 0, 0, 32'h0A0B0C0D, t_cap + PER, 0);
        idle(3);

        // stat_clr on the same edge as a passing verdict wins
        cyc(1, 8'h55, 0, 0, 0); cyc(1, 8'h66, 0, 0, 0); cyc(1, 8'h77, 0, 0, 0);
        cyc(1, 8'h88, 1, 32'h55667788, 0);
        expect_res(1, 0, 0, 32'h55667788, t_cap + PER, 1);
        cyc(0, 8'h00, 0, 0, 1);
        idle(3);
        // Counting resumes after the clear
        cyc(1, 8'h01, 1, 32'h01020304, 0);
        cyc(1, 8'h02, 0, 0, 0); cyc(1, 8'h03, 0, 0, 0); cyc(1, 8'h04, 0, 0, 0);
        expect_res(1, 0, 0, 32'h01020304, t_cap + PER, 0);
        idle(4);

        chk("pending_verdicts", 64'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
